div_int_seq: RTL and testbench
==============================

// Module: div_int_seq
// PURPOSE
//  Multi-cycle radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.
//  Signed or unsigned, selected per operation. One quotient bit per clock, start/busy/done handshake.
//  Reports divide-by-zero and quotient overflow separately.
//  Sits behind the ALU/MDU as the shared long-latency divide unit.
// PARAMETERS
//  W   32  divisor/quotient/remainder width; dividend is 2W; W >= 4
// PORTS
//  clk      in   1     clock, rising edge
//  rst      in   1     asynchronous reset, active high
//  start    in   1     request; sampled only in IDLE
//  sgn      in   1     1 = two's-complement operands/results, 0 = unsigned; captured with start
//  dnd      in   2W    dividend; captured with start
//  der      in   W     divisor; captured with start
//  busy     out  1     high from the edge that accepts start through the edge that raises done
//  done     out  1     one-cycle pulse; quo/rem/err/dbz valid from this cycle
//  quo      out  W     quotient, truncated toward zero
//  rem      out  W     remainder; sign follows the dividend; |rem| < |der|
//  err      out  1     result invalid: overflow or divide-by-zero
//  dbz      out  1     divisor was zero (implies err)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, quo=0, rem=0, err=0, dbz=0, internal regs 0.
//  FSM states: IDLE, PREP, CALC, FIX.
//   IDLE: start=1 at edge e0 -> capture sgn/dnd/der, busy=1, go PREP.
//   PREP (e1): form magnitudes |dnd| (2W bits, unsigned) and |der| (W bits); record result signs.
//         der==0 -> dbz=err flags set, go FIX.
//         |dnd|[2W-1:W] >= |der| -> unsigned quotient does not fit W bits; overflow flag set, go FIX.
//         otherwise: R = {1'b0, |dnd|[2W-1:W]}, S = |dnd|[W-1:0], cnt = W, go CALC.
//   CALC (edges e2..e(W+1)): R = {R[W-1:0], S[W-1]}; S <<= 1.
//         if R >= |der| then R -= |der|, S[0] = 1, else S[0] = 0. cnt--.
//         Leave for FIX after the W-th iteration.
//   FIX: when sgn=1:
//         q_neg = dnd[2W-1]^der[W-1]; r_neg = dnd[2W-1].
//         Overflow if (!q_neg && S > 2^(W-1)-1) or (q_neg && S > 2^(W-1)).
//         quo = q_neg ? -S : S; rem = r_neg ? -R : R.
//        When sgn=0: quo = S, rem = R.
//        Any error: err=1, quo=0, rem=0; dbz=1 only for the zero divisor.
//        The edge leaving FIX registers outputs, done=1, busy=0, returns to IDLE.
//  Latency: normal op done high after edge e(W+2), i.e. W+2 clocks after start accepted.
//   Error found in PREP: done after e2. Signed overflow found in FIX: full W+2.
//  done high exactly one cycle. quo/rem/err/dbz hold their values until the next done or reset.
//  start while busy=1 ignored: no capture, no queueing. start held high in IDLE after done starts a new op.
//  start at the same edge done is raised is ignored (state is FIX, not IDLE).
//  Operand inputs are don't-care after capture; changing them mid-op must not affect the result.
//  Reset mid-operation aborts: no done pulse. Outputs return to 0.
//  Magnitude of most-negative values: -2^(2W-1) -> 2^(2W-1), -2^(W-1) -> 2^(W-1). Both fit unsigned.
// TESTING (W=32)
//  T1 unsigned: dnd=100, der=7 -> quo=14, rem=2, err=0; done exactly 34 clocks after start.
//  T2 signed: dnd=-100, der=7 -> quo=0xFFFF_FFF2, rem=0xFFFF_FFFE.
//     dnd=100, der=-7 -> quo=0xFFFF_FFF2, rem=2.
//  T3 der=0, dnd=5, either sgn -> err=1, dbz=1, quo=0, rem=0; done 2 clocks after start.
//  T4 overflow: unsigned dnd=2^32, der=1 -> err=1, dbz=0, done at 2 clocks.
//     Signed dnd=2^31, der=1 -> err=1 at 34 clocks.
//     Signed dnd=-2^31, der=1 -> quo=0x8000_0000, err=0.
//  T5 start pulsed at clocks 5 and 20 of an active op, dnd/der changed mid-op -> single done, first operands' result.
//  T6 rst asserted mid-CALC between edges -> outputs 0 immediately (async).
//     No done; new op after release completes correctly (dnd=0xFFFF_FFFF_FFFF_FFFF unsigned, der=0xFFFF_FFFF -> err=1).

Source files
------------

// File: rtl/div_int_seq.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor.
// Produces one quotient bit per clock. Signed or unsigned is chosen per operation,
// and divide-by-zero and quotient overflow are reported separately.
module div_int_seq #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [2*W-1:0] dnd,
    input  logic [W-1:0]   der,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quo,
    output logic [W-1:0]   rem,
    output logic           err,
    output logic           dbz
);

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_MAG = {1'b1, {(W-1){1'b0}}};

    state_t state, state_next;

    logic           sgn_r;
    logic [2*W-1:0] dnd_r;
    logic [W-1:0]   der_r;
    logic [W-1:0]   abs_der_r;
    logic [W-1:0]   rem_acc;
    logic [W-1:0]   quo_acc;
    logic [CW-1:0]  cnt;
    logic           q_neg;
    logic           r_neg;
    logic           ovf_flag;
    logic           dbz_flag;

    logic [2*W-1:0] abs_dnd;
    logic [W-1:0]   abs_der;
    logic           prep_dbz;
    logic           prep_ovf;
    logic [W:0]     shifted;
    logic           fits;
    logic [W-1:0]   diff;
    logic           fix_ovf;
    logic           fix_err;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    // Magnitudes, PREP screening, one restoring step, and the final sign/overflow fix-up
    always_comb begin
        abs_dnd  = (sgn_r && dnd_r[2*W-1]) ? -dnd_r : dnd_r;
        abs_der  = (sgn_r && der_r[W-1]) ? -der_r : der_r;
        prep_dbz = (der_r == '0);
        prep_ovf = (abs_dnd[2*W-1:W] >= abs_der);

        shifted  = {rem_acc, quo_acc[W-1]};
        fits     = (shifted >= {1'b0, abs_der_r});
        diff     = shifted[W-1:0] - abs_der_r;

        fix_ovf  = sgn_r && ((!q_neg && (quo_acc > MAX_POS)) ||
                             ( q_neg && (quo_acc > MIN_MAG)));
        fix_err  = ovf_flag || dbz_flag || fix_ovf;
        quo_fix  = q_neg ? -quo_acc : quo_acc;
        rem_fix  = r_neg ? -rem_acc : rem_acc;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; PREP exits straight to FIX when the operands are already known bad
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = (prep_dbz || prep_ovf) ? FIX : CALC;
            CALC:    if (cnt == CW'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_r     <= 1'b0;
            dnd_r     <= '0;
            der_r     <= '0;
            abs_der_r <= '0;
            rem_acc   <= '0;
            quo_acc   <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            ovf_flag  <= 1'b0;
            dbz_flag  <= 1'b0;
            done      <= 1'b0;
            quo       <= '0;
            rem       <= '0;
            err       <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sgn_r <= sgn;
                        dnd_r <= dnd;
                        der_r <= der;
                    end
                end
                PREP: begin
                    abs_der_r <= abs_der;
                    q_neg     <= sgn_r & (dnd_r[2*W-1] ^ der_r[W-1]);
                    r_neg     <= sgn_r & dnd_r[2*W-1];
                    dbz_flag  <= prep_dbz;
                    ovf_flag  <= prep_ovf;
                    rem_acc   <= abs_dnd[2*W-1:W];
                    quo_acc   <= abs_dnd[W-1:0];
                    cnt       <= CW'(W);
                end
                CALC: begin
                    rem_acc <= fits ? diff : shifted[W-1:0];
                    quo_acc <= {quo_acc[W-2:0], fits};
                    cnt     <= cnt - CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    err  <= fix_err;
                    dbz  <= dbz_flag;
                    quo  <= fix_err ? '0 : quo_fix;
                    rem  <= fix_err ? '0 : rem_fix;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_int_seq.sv
// Self-checking bench for div_int_seq (W=32) using an expected-result queue.
module tb_div_int_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           sgn;
    logic [2*W-1:0] dnd;
    logic [W-1:0]   der;
    logic           busy;
    logic           done;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic           err;
    logic           dbz;

    typedef struct {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         err;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    div_int_seq #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .dnd   (dnd),
        .der   (der),
        .busy  (busy),
        .done  (done),
        .quo   (quo),
        .rem   (rem),
        .err   (err),
        .dbz   (dbz)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference: divide the magnitudes with native 64-bit arithmetic, then apply signs and range limits
    function automatic exp_t model(input logic s, input logic [63:0] a, input logic [31:0] b);
        exp_t         e;
        logic [63:0]  ma;
        logic [31:0]  mb;
        logic [63:0]  qm;
        logic [63:0]  rm;
        logic [31:0]  q32;
        logic [31:0]  r32;
        logic         qn;
        logic         rn;
        ma = (s && a[63]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        qn = s && (a[63] ^ b[31]);
        rn = s && a[63];
        e.quo = '0; e.rem = '0; e.err = 1'b0; e.dbz = 1'b0; e.lat = 2;
        if (b == 32'd0) begin
            e.err = 1'b1;
            e.dbz = 1'b1;
        end else begin
            qm = ma / {32'd0, mb};
            rm = ma % {32'd0, mb};
            if (qm > 64'h0000_0000_FFFF_FFFF) begin
                e.err = 1'b1;
            end else begin
                e.lat = W + 2;
                if (s && ((!qn && qm > 64'h7FFF_FFFF) || (qn && qm > 64'h8000_0000))) begin
                    e.err = 1'b1;
                end else begin
                    q32   = qm[31:0];
                    r32   = rm[31:0];
                    e.quo = qn ? -q32 : q32;
                    e.rem = rn ? -r32 : r32;
                end
            end
        end
        return e;
    endfunction

    task automatic apply_stimulus(input logic s, input logic [63:0] a, input logic [31:0] b, input exp_t e);
        @(negedge clk);
        sgn   = s;
        dnd   = a;
        der   = b;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        dnd   = '0;
        der   = '0;
        #12;
        checks++;
        if ({busy, done, quo, rem, err, dbz} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_hold: got busy=%b done=%b quo=%h rem=%h err=%b dbz=%b, need all 0",
                     busy, done, quo, rem, err, dbz);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quo, rem, err, dbz} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_release: got busy=%b done=%b quo=%h rem=%h err=%b dbz=%b, need all 0",
                     busy, done, quo, rem, err, dbz);
        end
    endtask

    task automatic test_arith;
        logic        s_tab [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] a_tab [7] = '{64'd100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd100, 64'hFFFF_FFFF_8000_0000,
                                   64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFE_FFFF_FFFF};
        logic [31:0] b_tab [7] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] q_tab [7] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'h8000_0000, 32'd0, 32'd3, 32'hFFFF_FFFF};
        logic [31:0] r_tab [7] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic        e_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t e;
        int   cyc;
        bit   ok;
        for (int i = 0; i < 7; i++) begin
            e.quo = q_tab[i]; e.rem = r_tab[i]; e.err = e_tab[i]; e.dbz = 1'b0; e.lat = W + 2;
            apply_stimulus(s_tab[i], a_tab[i], b_tab[i], e);
            wait_done(cyc, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL arith[%0d] done: none within %0d cycles", i, cyc);
                sb.delete();
            end else begin
                e = sb.pop_front();
                checks++;
                if ({quo, rem, err, dbz} !== {e.quo, e.rem, e.err, e.dbz}) begin
                    failures++;
                    $display("[TB] FAIL arith[%0d] result: got quo=%h rem=%h err=%b dbz=%b, need quo=%h rem=%h err=%b dbz=%b",
                             i, quo, rem, err, dbz, e.quo, e.rem, e.err, e.dbz);
                end
                checks++;
                if (cyc != e.lat) begin
                    failures++;
                    $display("[TB] FAIL arith[%0d] latency: got %0d, need %0d", i, cyc, e.lat);
                end
            end
        end
    endtask

    task automatic test_errors;
        logic        s_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [63:0] a_tab [5] = '{64'd5, 64'd5, 64'h0000_0001_0000_0000, 64'h0000_0000_8000_0000,
                                   64'h8000_0000_0000_0000};
        logic [31:0] b_tab [5] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'hFFFF_FFFF};
        logic        d_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int          l_tab [5] = '{2, 2, 2, W + 2, 2};
        exp_t e;
        int   cyc;
        bit   ok;
        for (int i = 0; i < 5; i++) begin
            e.quo = '0; e.rem = '0; e.err = 1'b1; e.dbz = d_tab[i]; e.lat = l_tab[i];
            apply_stimulus(s_tab[i], a_tab[i], b_tab[i], e);
            wait_done(cyc, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL error[%0d] done: none within %0d cycles", i, cyc);
                sb.delete();
            end else begin
                e = sb.pop_front();
                checks++;
                if ({quo, rem, err, dbz} !== {e.quo, e.rem, e.err, e.dbz}) begin
                    failures++;
                    $display("[TB] FAIL error[%0d] result: got quo=%h rem=%h err=%b dbz=%b, need quo=%h rem=%h err=%b dbz=%b",
                             i, quo, rem, err, dbz, e.quo, e.rem, e.err, e.dbz);
                end
                checks++;
                if (cyc != e.lat) begin
                    failures++;
                    $display("[TB] FAIL error[%0d] latency: got %0d, need %0d", i, cyc, e.lat);
                end
            end
        end
    endtask

    task automatic test_random;
        logic        s;
        logic [63:0] a;
        logic [31:0] b;
        logic [31:0] r;
        exp_t e;
        int   cyc;
        bit   ok;
        for (int i = 0; i < 10; i++) begin
            b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (b == 32'd0) b = 32'd1;
            r = $urandom;
            if (i % 2 == 0) begin
                s = 1'b0;
                a = {$urandom % b, r};
            end else begin
                s = 1'b1;
                a = {{32{r[31]}}, r};
            end
            e = model(s, a, b);
            apply_stimulus(s, a, b, e);
            wait_done(cyc, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL random[%0d] done: none within %0d cycles", i, cyc);
                sb.delete();
            end else begin
                e = sb.pop_front();
                checks++;
                if ({quo, rem, err, dbz} !== {e.quo, e.rem, e.err, e.dbz}) begin
                    failures++;
                    $display("[TB] FAIL random[%0d] result (sgn=%b dnd=%h der=%h): got quo=%h rem=%h err=%b dbz=%b, need quo=%h rem=%h err=%b dbz=%b",
                             i, s, a, b, quo, rem, err, dbz, e.quo, e.rem, e.err, e.dbz);
                end
                checks++;
                if (cyc != e.lat) begin
                    failures++;
                    $display("[TB] FAIL random[%0d] latency: got %0d, need %0d", i, cyc, e.lat);
                end
            end
        end
    endtask

    task automatic test_ignore_start;
        exp_t e;
        int   cyc;
        int   extra;
        bit   ok;
        bit   bad_busy;
        e.quo = 32'd333; e.rem = 32'd1; e.err = 1'b0; e.dbz = 1'b0; e.lat = W + 2;
        apply_stimulus(1'b0, 64'd1000, 32'd3, e);
        cyc = 0; ok = 1'b0; bad_busy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (!busy) bad_busy = 1'b1;
            if (cyc == 5 || cyc == 20) begin
                start = 1'b1;
                sgn   = 1'($urandom);
                dnd   = {$urandom, $urandom};
                der   = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (bad_busy) begin
            failures++;
            $display("[TB] FAIL ignore busy: got busy=0 before done, need 1");
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL ignore done: none within %0d cycles", cyc);
            sb.delete();
        end else begin
            e = sb.pop_front();
            checks++;
            if ({quo, rem, err, dbz} !== {e.quo, e.rem, e.err, e.dbz}) begin
                failures++;
                $display("[TB] FAIL ignore result: got quo=%h rem=%h err=%b dbz=%b, need quo=%h rem=%h err=%b dbz=%b",
                         quo, rem, err, dbz, e.quo, e.rem, e.err, e.dbz);
            end
            checks++;
            if (cyc != e.lat) begin
                failures++;
                $display("[TB] FAIL ignore latency: got %0d, need %0d", cyc, e.lat);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL ignore busy_at_done: got %b, need 0", busy);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignore done_pulse: got done=%b one cycle later, need 0", done);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("[TB] FAIL ignore queued_op: got %0d extra done pulses, need 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   cyc;
        bit   ok;
        @(negedge clk);
        sgn   = 1'b0;
        dnd   = 64'd100;
        der   = 32'd7;
        start = 1'b1;
        e.quo = 32'd14; e.rem = 32'd2; e.err = 1'b0; e.dbz = 1'b0; e.lat = W + 2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            wait_done(cyc, ok);
            if (k == 0) begin
                sgn = 1'b1;
                dnd = 64'hFFFF_FFFF_FFFF_FF9C;
                der = 32'd7;
                e.quo = 32'hFFFF_FFF2; e.rem = 32'hFFFF_FFFE; e.err = 1'b0; e.dbz = 1'b0; e.lat = W + 3;
                sb.push_back(e);
            end else begin
                start = 1'b0;
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL b2b[%0d] done: none within %0d cycles", k, cyc);
                start = 1'b0;
                sb.delete();
                break;
            end else begin
                e = sb.pop_front();
                checks++;
                if ({quo, rem, err, dbz} !== {e.quo, e.rem, e.err, e.dbz}) begin
                    failures++;
                    $display("[TB] FAIL b2b[%0d] result: got quo=%h rem=%h err=%b dbz=%b, need quo=%h rem=%h err=%b dbz=%b",
                             k, quo, rem, err, dbz, e.quo, e.rem, e.err, e.dbz);
                end
                checks++;
                if (cyc != e.lat) begin
                    failures++;
                    $display("[TB] FAIL b2b[%0d] latency: got %0d, need %0d", k, cyc, e.lat);
                end
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_abort;
        exp_t e;
        int   cyc;
        int   extra;
        bit   ok;
        e.quo = 32'd124703; e.rem = 32'd81; e.err = 1'b0; e.dbz = 1'b0; e.lat = W + 2;
        apply_stimulus(1'b0, 64'd12345678, 32'd99, e);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({quo, rem} !== {32'hFFFF_FFF2, 32'hFFFF_FFFE}) begin
            failures++;
            $display("[TB] FAIL abort hold: got quo=%h rem=%h mid-op, need quo=fffffff2 rem=fffffffe", quo, rem);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, quo, rem, err, dbz} !== '0) begin
            failures++;
            $display("[TB] FAIL abort async_clear: got busy=%b done=%b quo=%h rem=%h err=%b dbz=%b, need all 0",
                     busy, done, quo, rem, err, dbz);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("[TB] FAIL abort no_done: got %0d done pulses after abort, need 0", extra);
        end
        e.quo = '0; e.rem = '0; e.err = 1'b1; e.dbz = 1'b0; e.lat = 2;
        apply_stimulus(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, e);
        wait_done(cyc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL abort restart done: none within %0d cycles", cyc);
            sb.delete();
        end else begin
            e = sb.pop_front();
            checks++;
            if ({quo, rem, err, dbz} !== {e.quo, e.rem, e.err, e.dbz}) begin
                failures++;
                $display("[TB] FAIL abort restart result: got quo=%h rem=%h err=%b dbz=%b, need quo=%h rem=%h err=%b dbz=%b",
                         quo, rem, err, dbz, e.quo, e.rem, e.err, e.dbz);
            end
            checks++;
            if (cyc != e.lat) begin
                failures++;
                $display("[TB] FAIL abort restart latency: got %0d, need %0d", cyc, e.lat);
            end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_arith();
        test_errors();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the design wedges the bench
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
